// File: rtl/adc_trig_capture.sv
// rtl/adc_trig_capture.sv - ADC trigger-and-capture stage with circular buffer and stream readout
//
// Purpose:
//   Records channel sample pairs into a circular buffer once armed. It
//   detects a level crossing (or a forced trigger) on the selected channel
//   and freezes a window of P pre-trigger and 2^DEPTH_LOG2 - P post-trigger
//   samples. The window is then streamed out oldest-first.
//
// Ports:
//   TrgClk, TrgRst           sample clock, asynchronous active-high reset
//   TrgDataCh0/Ch1/Valid     incoming sample pair and its valid flag
//   TrgArm, TrgForce         arm pulse (IDLE only), force-trigger pulse (WAIT only)
//   TrgChSel, TrgSlope       trigger channel (0=Ch0) and slope (1=rising)
//   TrgLevel, TrgPreCnt      trigger threshold (unsigned), pre-trigger sample count
//   TrgBusy, TrgDone         not-idle flag, one-cycle end-of-readout pulse
//   m_axis_*                 readout stream, tdata = {Ch1, Ch0}
module adc_trig_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input  logic                  TrgClk,
  input  logic                  TrgRst,
  input  logic [DATA_W-1:0]     TrgDataCh0,
  input  logic [DATA_W-1:0]     TrgDataCh1,
  input  logic                  TrgDataValid,
  input  logic                  TrgArm,
  input  logic                  TrgForce,
  input  logic                  TrgChSel,
  input  logic                  TrgSlope,
  input  logic [DATA_W-1:0]     TrgLevel,
  input  logic [DEPTH_LOG2-1:0] TrgPreCnt,
  output logic                  TrgBusy,
  output logic                  TrgDone,
  output logic [2*DATA_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Counters need one extra bit: with P=0 the post count reaches DEPTH.
  localparam int CW = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_READ
  } state_t;

  state_t state, state_nxt;

  logic [2*DATA_W-1:0]   mem [DEPTH];

  logic                  cfg_ch_sel;
  logic                  cfg_slope;
  logic [DATA_W-1:0]     cfg_level;
  logic [DEPTH_LOG2-1:0] cfg_pre;

  logic [DEPTH_LOG2-1:0] wptr;
  logic [CW-1:0]         cnt;
  logic [DATA_W-1:0]     prev;
  logic                  prev_valid;
  logic                  force_flag;

  logic [DATA_W-1:0]     cur;
  logic                  edge_hit;
  logic                  arm_ok;
  logic                  wr_en;
  logic                  trig;
  logic                  pre_last;
  logic                  post_last;
  logic [CW-1:0]         post_target;

  logic [CW-1:0]         rd_cnt;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  rd_issue_ok;
  logic                  rd_en;
  logic [2*DATA_W-1:0]   ram_q;
  logic                  ram_vld;
  logic                  ram_last;
  logic                  out_load;
  logic                  beat_done;
  logic                  busy;

  // ---------------------------------------------------------------------
  // Trigger detection and counter terminal conditions
  // ---------------------------------------------------------------------
  assign cur         = cfg_ch_sel ? TrgDataCh1 : TrgDataCh0;
  assign edge_hit    = prev_valid &&
                       (cfg_slope ? ((prev < cfg_level) && (cur >= cfg_level))
                                  : ((prev > cfg_level) && (cur <= cfg_level)));
  assign arm_ok      = (state == ST_IDLE) && TrgArm;
  // A pending force and an edge on the same sample collapse into one trigger.
  assign trig        = (state == ST_WAIT) && TrgDataValid && (force_flag || edge_hit);
  assign post_target = CW'(DEPTH) - {1'b0, cfg_pre};
  assign pre_last    = (cnt + CW'(1)) == {1'b0, cfg_pre};
  assign post_last   = (cnt + CW'(1)) == post_target;
  assign beat_done   = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge TrgClk or posedge TrgRst) begin
    if (TrgRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (TrgArm) begin
          state_nxt = (TrgPreCnt == '0) ? ST_WAIT : ST_PRE;
        end
      end
      ST_PRE: begin
        if (TrgDataValid && pre_last) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (trig) begin
          // With P = DEPTH-1 the trigger sample alone completes the window.
          state_nxt = (post_target == CW'(1)) ? ST_READ : ST_POST;
        end
      end
      ST_POST: begin
        if (TrgDataValid && post_last) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (beat_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy        = 1'b0;
    wr_en       = 1'b0;
    rd_issue_ok = 1'b0;
    case (state)
      ST_PRE, ST_WAIT, ST_POST: begin
        busy  = 1'b1;
        wr_en = TrgDataValid;
      end
      ST_READ: begin
        busy        = 1'b1;
        rd_issue_ok = rd_cnt < CW'(DEPTH);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign TrgBusy = busy;

  // ---------------------------------------------------------------------
  // Capture datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge TrgClk or posedge TrgRst) begin
    if (TrgRst) begin
      cfg_ch_sel <= 1'b0;
      cfg_slope  <= 1'b0;
      cfg_level  <= '0;
      cfg_pre    <= '0;
      wptr       <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      force_flag <= 1'b0;
    end else begin
      if (arm_ok) begin
        cfg_ch_sel <= TrgChSel;
        cfg_slope  <= TrgSlope;
        cfg_level  <= TrgLevel;
        cfg_pre    <= TrgPreCnt;
        wptr       <= '0;
        cnt        <= '0;
        prev_valid <= 1'b0;
        force_flag <= 1'b0;
      end else begin
        if (wr_en) begin
          wptr <= wptr + 1'b1;
        end

        if (trig) begin
          cnt <= CW'(1);
        end else if (TrgDataValid && ((state == ST_PRE) || (state == ST_POST))) begin
          cnt <= cnt + CW'(1);
        end

        if (TrgDataValid && ((state == ST_PRE) || (state == ST_WAIT))) begin
          prev       <= cur;
          prev_valid <= 1'b1;
        end

        if ((state == ST_WAIT) && TrgForce) begin
          force_flag <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sample buffer. Once POST completes, wptr has advanced DEPTH-P past
  // the trigger address, so it already points at the oldest sample of the
  // window (TrigAddr - P); writes stop in READ, leaving wptr frozen.
  // ---------------------------------------------------------------------
  assign rd_addr = wptr + rd_cnt[DEPTH_LOG2-1:0];

  always_ff @(posedge TrgClk) begin
    if (wr_en) begin
      mem[wptr] <= {TrgDataCh1, TrgDataCh0};
    end
    if (rd_en) begin
      ram_q <= mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------------
  // Readout: the RAM read register acts as a holding slot in front of the
  // output register, so a stalled sink never loses an issued read and an
  // unstalled sink gets one beat per cycle.
  // ---------------------------------------------------------------------
  assign out_load = ram_vld && (!m_axis_tvalid || m_axis_tready);
  assign rd_en    = rd_issue_ok && (!ram_vld || out_load);

  always_ff @(posedge TrgClk or posedge TrgRst) begin
    if (TrgRst) begin
      rd_cnt   <= '0;
      ram_vld  <= 1'b0;
      ram_last <= 1'b0;
    end else if (state != ST_READ) begin
      rd_cnt   <= '0;
      ram_vld  <= 1'b0;
      ram_last <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_cnt   <= rd_cnt + CW'(1);
        ram_vld  <= 1'b1;
        ram_last <= rd_cnt == CW'(DEPTH - 1);
      end else if (out_load) begin
        ram_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge TrgClk or posedge TrgRst) begin
    if (TrgRst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      TrgDone       <= 1'b0;
    end else begin
      if (out_load) begin
        m_axis_tdata  <= ram_q;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= ram_last;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      // Registered so it lines up with the first IDLE cycle (TrgBusy low).
      TrgDone <= beat_done;
    end
  end

endmodule

// File: tb/tb_adc_trig_capture.sv
// tb/tb_adc_trig_capture.sv - self-checking bench for adc_trig_capture
module tb_adc_trig_capture;

  localparam int DL    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << DL;

  logic          TrgClk = 1'b0;
  logic          TrgRst;
  logic [DW-1:0] TrgDataCh0;
  logic [DW-1:0] TrgDataCh1;
  logic          TrgDataValid;
  logic          TrgArm;
  logic          TrgForce;
  logic          TrgChSel;
  logic          TrgSlope;
  logic [DW-1:0] TrgLevel;
  logic [DL-1:0] TrgPreCnt;
  logic          TrgBusy;
  logic          TrgDone;
  logic [2*DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  adc_trig_capture #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
    .TrgClk        (TrgClk),
    .TrgRst        (TrgRst),
    .TrgDataCh0    (TrgDataCh0),
    .TrgDataCh1    (TrgDataCh1),
    .TrgDataValid  (TrgDataValid),
    .TrgArm        (TrgArm),
    .TrgForce      (TrgForce),
    .TrgChSel      (TrgChSel),
    .TrgSlope      (TrgSlope),
    .TrgLevel      (TrgLevel),
    .TrgPreCnt     (TrgPreCnt),
    .TrgBusy       (TrgBusy),
    .TrgDone       (TrgDone),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 TrgClk = ~TrgClk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            mode;      // 0 ramp ch0, 1 up/down ch1, 2 constant+force, 3 random+valid gating+force
    bit            ch_sel;
    bit            slope;
    logic [DW-1:0] level;
    int            pre;
    bit            rdy_rand;
    bit            arm_noise;
    int            force_n;   // cycle index after arm of the force pulse, -1 none
    bit            has_const;
    logic [DW-1:0] exp_first; // selected channel of beat 0
    logic [DW-1:0] exp_trig;  // selected channel of beat P (trigger sample)
  } tvec_t;

  tvec_t tv[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic gen(input int mode, input int n, input int force_n,
                     output logic [DW-1:0] c0, output logic [DW-1:0] c1,
                     output logic vld, output logic frc);
    frc = 1'b0;
    vld = 1'b1;
    case (mode)
      0: begin
        c0 = DW'(90 + n);
        c1 = DW'(n * 3);
      end
      1: begin
        c0 = DW'($urandom);
        c1 = (n <= 20) ? DW'(40 + n) : DW'(80 - n);
      end
      2: begin
        c0 = 16'h1234;
        c1 = 16'h1234;
        if (n == force_n) begin
          vld = 1'b0;
          frc = 1'b1;
        end
      end
      default: begin
        c0 = DW'($urandom_range(0, 16'hFFFE));
        c1 = DW'($urandom);
        if (n == force_n) begin
          vld = 1'b0;
          frc = 1'b1;
        end else begin
          vld = (n < 8) ? 1'b1 : 1'($urandom % 2);
        end
      end
    endcase
  endtask

  function automatic logic [DW-1:0] sel_ch(input logic [2*DW-1:0] s, input bit ch);
    return ch ? s[2*DW-1:DW] : s[DW-1:0];
  endfunction

  task automatic run_capture(input tvec_t v, input int tag);
    logic [2*DW-1:0] samp[$];
    logic [2*DW-1:0] beats[$];
    logic            lasts[$];
    int              force_at = -1;
    int              dones = 0;
    bit              done_seen = 0;
    bit              stall = 0;
    logic [2*DW-1:0] hold_d = '0;
    logic            hold_l = 1'b0;
    logic [DW-1:0]   c0, c1, pv, cu;
    logic            vl, fr;
    int              t;
    @(negedge TrgClk);
    TrgChSel = v.ch_sel; TrgSlope = v.slope; TrgLevel = v.level;
    TrgPreCnt = DL'(v.pre); TrgArm = 1'b1; TrgDataValid = 1'b0; TrgForce = 1'b0;
    m_axis_tready = 1'b0;
    @(negedge TrgClk);
    TrgArm = 1'b0;
    chk($sformatf("v%0d_busy_after_arm", tag), TrgBusy, 1);
    // Configuration must be latched at arm; scramble it now.
    TrgChSel = ~v.ch_sel; TrgSlope = ~v.slope; TrgLevel = DW'($urandom); TrgPreCnt = DL'($urandom);
    for (int n = 0; n < 400 && !done_seen; n++) begin
      if (n > 0) @(negedge TrgClk);
      if (TrgDone) begin
        dones++;
        done_seen = 1;
        chk($sformatf("v%0d_busy_at_done", tag), TrgBusy, 0);
      end
      if (stall) begin
        chk($sformatf("v%0d_stall_valid", tag), m_axis_tvalid, 1);
        chk($sformatf("v%0d_stall_data", tag), m_axis_tdata, hold_d);
        chk($sformatf("v%0d_stall_last", tag), m_axis_tlast, hold_l);
      end
      gen(v.mode, n, v.force_n, c0, c1, vl, fr);
      TrgDataCh0 = c0; TrgDataCh1 = c1; TrgDataValid = vl; TrgForce = fr;
      if (vl) samp.push_back({c1, c0});
      if (fr) force_at = samp.size();
      m_axis_tready = v.rdy_rand ? 1'($urandom % 2) : 1'b1;
      TrgArm = (v.arm_noise && beats.size() > 0 && !done_seen) ? 1'($urandom % 2) : 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        beats.push_back(m_axis_tdata);
        lasts.push_back(m_axis_tlast);
      end
      stall  = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      hold_l = m_axis_tlast;
    end
    if (!done_seen) chk($sformatf("v%0d_timeout_done", tag), 0, 1);
    TrgArm = 1'b0; TrgDataValid = 1'b0; TrgForce = 1'b0;
    @(negedge TrgClk);
    chk($sformatf("v%0d_done_one_cycle", tag), TrgDone, 0);
    @(negedge TrgClk);
    @(negedge TrgClk);
    chk($sformatf("v%0d_idle_after_done", tag), TrgBusy, 0);

    // Reference: trigger is the first sample at index >= P that is forced
    // or crosses the level relative to its predecessor; window is P before it.
    t = -1;
    for (int i = v.pre; i < samp.size() && t < 0; i++) begin
      cu = sel_ch(samp[i], v.ch_sel);
      if (force_at >= 0 && i >= force_at) begin
        t = i;
      end else if (i >= 1) begin
        pv = sel_ch(samp[i-1], v.ch_sel);
        if (v.slope ? ((pv < v.level) && (cu >= v.level)) : ((pv > v.level) && (cu <= v.level)))
          t = i;
      end
    end
    chk($sformatf("v%0d_beat_count", tag), beats.size(), DEPTH);
    chk($sformatf("v%0d_done_count", tag), dones, 1);
    if (t < 0 || t - v.pre + DEPTH > samp.size()) begin
      chk($sformatf("v%0d_model_window", tag), 0, 1);
    end else begin
      for (int j = 0; j < beats.size() && j < DEPTH; j++) begin
        chk($sformatf("v%0d_beat%0d_data", tag, j), beats[j], samp[t - v.pre + j]);
        chk($sformatf("v%0d_beat%0d_last", tag, j), lasts[j], (j == DEPTH - 1));
      end
    end
    if (v.has_const && beats.size() == DEPTH) begin
      chk($sformatf("v%0d_first_beat", tag), sel_ch(beats[0], v.ch_sel), v.exp_first);
      chk($sformatf("v%0d_trig_beat", tag), sel_ch(beats[v.pre], v.ch_sel), v.exp_trig);
    end
  endtask

  logic [DW-1:0] rc0, rc1;
  logic          rvl, rfr;

  initial begin
    //            mode sel slope level     pre rdy arm  force const first    trig
    tv[0] = '{0,   0,  1,   16'd100,   4,  0,  0,   -1,   1,   16'd96,   16'd100};
    tv[1] = '{1,   1,  0,   16'd50,    4,  0,  0,   -1,   1,   16'd54,   16'd50};
    tv[2] = '{2,   0,  1,   16'd0,     0,  0,  0,   6,    1,   16'h1234, 16'h1234};
    tv[3] = '{3,   0,  1,   16'hFFFF,  5,  0,  0,   70,   0,   16'd0,    16'd0};
    tv[4] = '{0,   0,  1,   16'd100,   4,  1,  1,   -1,   1,   16'd96,   16'd100};

    TrgRst = 1'b1; TrgDataCh0 = '0; TrgDataCh1 = '0; TrgDataValid = 1'b0;
    TrgArm = 1'b0; TrgForce = 1'b0; TrgChSel = 1'b0; TrgSlope = 1'b0;
    TrgLevel = '0; TrgPreCnt = '0; m_axis_tready = 1'b0;
    @(negedge TrgClk);
    @(negedge TrgClk);
    chk("rst_busy",  TrgBusy, 0);
    chk("rst_done",  TrgDone, 0);
    chk("rst_valid", m_axis_tvalid, 0);
    chk("rst_last",  m_axis_tlast, 0);
    chk("rst_data",  m_axis_tdata, 0);
    TrgRst = 1'b0;
    @(negedge TrgClk);

    for (int k = 0; k < 5; k++) run_capture(tv[k], k);

    // Reset during POST, then the rising scenario must repeat exactly.
    @(negedge TrgClk);
    TrgChSel = 1'b0; TrgSlope = 1'b1; TrgLevel = 16'd100; TrgPreCnt = DL'(4); TrgArm = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge TrgClk);
    TrgArm = 1'b0;
    for (int n = 0; n < 14; n++) begin
      if (n > 0) @(negedge TrgClk);
      gen(0, n, -1, rc0, rc1, rvl, rfr);
      TrgDataCh0 = rc0; TrgDataCh1 = rc1; TrgDataValid = rvl;
    end
    @(negedge TrgClk);
    chk("busy_before_reset", TrgBusy, 1);
    TrgRst = 1'b1;
    #1;
    chk("midrst_busy",  TrgBusy, 0);
    chk("midrst_valid", m_axis_tvalid, 0);
    chk("midrst_done",  TrgDone, 0);
    @(negedge TrgClk);
    TrgRst = 1'b0; TrgDataValid = 1'b0;
    @(negedge TrgClk);
    run_capture(tv[0], 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
